// File: rtl/fifo_msg_reader_if.sv
// fifo_msg_reader_if
//   Bundles the two handshakes that fifo_msg_reader sits between:
//   the FIFO dequeue port and the ready/valid message output.
//
//   Parameter
//     width      data word width, shared by the FIFO and the output
//
//   Signals
//     F_EMPTY_N  FIFO has a word and F_DATA is valid
//     F_DATA     FIFO head word
//     F_DEQ      dequeue strobe to the FIFO
//     M_VALID    output beat valid
//     M_READY    consumer accepts the beat
//     M_DATA     output beat data
//     M_SOM      first beat of a message
//     M_EOM      last beat of a message
//
//   Modports
//     master     the reader (drives F_DEQ and the M_* beat)
//     slave      the environment (FIFO plus consumer)

interface fifo_msg_reader_if #(
  parameter int width = 128
);

  logic             F_EMPTY_N;
  logic [width-1:0] F_DATA;
  logic             F_DEQ;
  logic             M_VALID;
  logic             M_READY;
  logic [width-1:0] M_DATA;
  logic             M_SOM;
  logic             M_EOM;

  modport master (
    input  F_EMPTY_N, F_DATA, M_READY,
    output F_DEQ, M_VALID, M_DATA, M_SOM, M_EOM
  );

  modport slave (
    output F_EMPTY_N, F_DATA, M_READY,
    input  F_DEQ, M_VALID, M_DATA, M_SOM, M_EOM
  );

endinterface

// File: rtl/fifo_msg_reader.sv
// fifo_msg_reader
//   Read-side framer for the SRL FIFO family. It drains a FIFO whose
//   stream is made of messages. Each message is one header word that
//   carries the payload length in its low lenw bits, followed by that
//   many payload words. The payload is presented on a one-deep registered
//   ready/valid output with SOM/EOM framing. The block also counts
//   completed messages and zero-length messages.
//
//   Optional feature: define FIFO_MSG_READER_HDR_PASS_EN to forward the
//   header word as the first beat of each message. Without the macro,
//   headers are consumed silently and zero-length messages produce no
//   beat.
//
//   Parameters
//     width      data word width (FIFO and output)
//     lenw       header length field width, lenw <= width
//
//   Ports
//     CLK        sole clock, rising edge
//     RST_N      asynchronous active-low reset
//     CLR        synchronous clear, same effect as reset
//     bus        fifo_msg_reader_if.master (FIFO dequeue + message output)
//     MSG_COUNT  completed messages, wraps modulo 2^32
//     ZLM_COUNT  zero-length messages consumed, saturates at 16'hFFFF
//     BUSY       a message is in progress or a beat is pending

module fifo_msg_reader #(
  parameter int width = 128,
  parameter int lenw  = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CLR,
  fifo_msg_reader_if.master   bus,
  output logic [31:0]         MSG_COUNT,
  output logic [15:0]         ZLM_COUNT,
  output logic                BUSY
);

  typedef enum logic {
    IDLE,
    DATA
  } state_t;

  localparam logic [lenw-1:0] LEN_ONE = lenw'(1);

  state_t           state, state_nxt;
  logic [lenw-1:0]  remaining, remaining_nxt;
  logic             first, first_nxt;
  logic             m_valid, m_valid_nxt;
  logic             m_som, m_som_nxt;
  logic             m_eom, m_eom_nxt;
  logic [width-1:0] m_data, m_data_nxt;
  logic [31:0]      msg_count;
  logic [15:0]      zlm_count;
  logic             msg_inc;
  logic             zlm_inc;
  logic             slot_free;
  logic             deq;
  logic [lenw-1:0]  hdr_len;

  // The output register can take a new beat when it is empty or its
  // current beat leaves on this edge.
  assign slot_free = !m_valid || bus.M_READY;
  assign hdr_len   = bus.F_DATA[lenw-1:0];

  // Next-state and dequeue decision. The dequeue strobe is gated by
  // reset and CLR so the FIFO never loses a word that this block would
  // discard anyway. It is also gated by F_EMPTY_N so the FIFO never
  // underflows.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    first_nxt     = first;
    m_valid_nxt   = m_valid;
    m_som_nxt     = m_som;
    m_eom_nxt     = m_eom;
    m_data_nxt    = m_data;
    msg_inc       = 1'b0;
    zlm_inc       = 1'b0;
    deq           = 1'b0;

    if (RST_N && !CLR) begin
      case (state)
`ifdef FIFO_MSG_READER_HDR_PASS_EN
        IDLE:    deq = bus.F_EMPTY_N && slot_free;
`else
        // The header is swallowed here, so a pending last beat of the
        // previous message does not hold up the next header.
        IDLE:    deq = bus.F_EMPTY_N;
`endif
        DATA:    deq = bus.F_EMPTY_N && slot_free;
        default: deq = 1'b0;
      endcase
    end

    // A beat taken by the consumer empties the register. A load below
    // overrides this on the same edge.
    if (m_valid && bus.M_READY) begin
      m_valid_nxt = 1'b0;
      m_som_nxt   = 1'b0;
      m_eom_nxt   = 1'b0;
    end

    if (deq) begin
      case (state)
        IDLE: begin
`ifdef FIFO_MSG_READER_HDR_PASS_EN
          m_data_nxt  = bus.F_DATA;
          m_valid_nxt = 1'b1;
          m_som_nxt   = 1'b1;
          m_eom_nxt   = (hdr_len == '0);
`endif
          if (hdr_len == '0) begin
            zlm_inc = 1'b1;
`ifdef FIFO_MSG_READER_HDR_PASS_EN
            msg_inc = 1'b1;
`endif
          end else begin
            remaining_nxt = hdr_len;
            state_nxt     = DATA;
`ifdef FIFO_MSG_READER_HDR_PASS_EN
            // The header beat already carried SOM.
            first_nxt     = 1'b0;
`else
            first_nxt     = 1'b1;
`endif
          end
        end
        DATA: begin
          m_data_nxt    = bus.F_DATA;
          m_valid_nxt   = 1'b1;
          m_som_nxt     = first;
          m_eom_nxt     = (remaining == LEN_ONE);
          first_nxt     = 1'b0;
          // remaining is at least one here, so a maximum-length header
          // counts down to zero without wrapping.
          remaining_nxt = remaining - LEN_ONE;
          if (remaining == LEN_ONE) begin
            state_nxt = IDLE;
            msg_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, output beat register and counters. CLR behaves like reset
  // and also drops any undelivered beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      m_valid   <= 1'b0;
      m_som     <= 1'b0;
      m_eom     <= 1'b0;
      m_data    <= '0;
      msg_count <= '0;
      zlm_count <= '0;
    end else if (CLR) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      m_valid   <= 1'b0;
      m_som     <= 1'b0;
      m_eom     <= 1'b0;
      m_data    <= '0;
      msg_count <= '0;
      zlm_count <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      first     <= first_nxt;
      m_valid   <= m_valid_nxt;
      m_som     <= m_som_nxt;
      m_eom     <= m_eom_nxt;
      m_data    <= m_data_nxt;
      if (msg_inc) begin
        msg_count <= msg_count + 32'd1;
      end
      if (zlm_inc && (zlm_count != 16'hFFFF)) begin
        zlm_count <= zlm_count + 16'd1;
      end
    end
  end

  assign bus.F_DEQ   = deq;
  assign bus.M_VALID = m_valid;
  assign bus.M_DATA  = m_data;
  assign bus.M_SOM   = m_som;
  assign bus.M_EOM   = m_eom;
  assign MSG_COUNT   = msg_count;
  assign ZLM_COUNT   = zlm_count;
  assign BUSY        = (state != IDLE) || m_valid;

endmodule

// File: tb/tb_fifo_msg_reader.sv
// tb_fifo_msg_reader
//   Directed bench for fifo_msg_reader. A queue stands in for the FIFO.
//   Each table row describes one clock cycle: the inputs (CLR, FIFO
//   availability gate, M_READY) and the F_DEQ and output values expected
//   in that cycle. The expected values were worked out by hand. Two
//   hand-written sequences cover a maximum-length message and an
//   asynchronous reset in the middle of a message.

module tb_fifo_msg_reader;

  localparam int WIDTH = 128;
  localparam int LENW  = 16;

  typedef struct {
    logic             clr;
    logic             gate;
    logic             ready;
    logic             expDeq;
    logic             expValid;
    logic [WIDTH-1:0] expData;
    logic             expSom;
    logic             expEom;
    logic [31:0]      expMsg;
    logic [15:0]      expZlm;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CLR;
  logic [31:0] msgCount;
  logic [15:0] zlmCount;
  logic        busy;

  logic [WIDTH-1:0] fifoQ[$];
  logic             fifoGate;
  vec_t             vecs[$];
  int               vecCount  = 0;
  int               missCount = 0;

  fifo_msg_reader_if #(.width(WIDTH)) bus ();

  fifo_msg_reader #(.width(WIDTH), .lenw(LENW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (CLR),
    .bus       (bus),
    .MSG_COUNT (msgCount),
    .ZLM_COUNT (zlmCount),
    .BUSY      (busy)
  );

  always #5 CLK = ~CLK;

  // Header words carry junk above the length field to show that only the
  // low lenw bits count.
  localparam logic [WIDTH-1:0] H0    = {112'hDEAD, 16'd0};
  localparam logic [WIDTH-1:0] H1    = {112'hBEEF, 16'd1};
  localparam logic [WIDTH-1:0] H2    = {112'hCAFE, 16'd2};
  localparam logic [WIDTH-1:0] H3    = {112'hF00D, 16'd3};
  localparam logic [WIDTH-1:0] H4    = {112'hFACE, 16'd4};
  localparam logic [WIDTH-1:0] WA    = 128'hA1;
  localparam logic [WIDTH-1:0] WB    = 128'hB2;
  localparam logic [WIDTH-1:0] WC    = 128'hC3;
  localparam logic [WIDTH-1:0] WD    = 128'hD4;
  localparam logic [WIDTH-1:0] P1    = 128'h1001;
  localparam logic [WIDTH-1:0] P2    = 128'h1002;
  localparam logic [WIDTH-1:0] P3    = 128'h1003;
  localparam logic [WIDTH-1:0] P4    = 128'h1004;
  localparam logic [WIDTH-1:0] E1    = 128'hE1;
  localparam logic [WIDTH-1:0] E2    = 128'hE2;
  localparam logic [WIDTH-1:0] E3HDR = {112'h00E3, 16'd1};
  localparam logic [WIDTH-1:0] E4    = 128'hE4;
  localparam logic [WIDTH-1:0] Q1    = 128'h51;
  localparam logic [WIDTH-1:0] Q2    = 128'h52;
  localparam logic [WIDTH-1:0] WX    = 128'h77;
  localparam logic [WIDTH-1:0] WY    = 128'h88;
  localparam logic [WIDTH-1:0] NONE  = '0;

  function automatic void addVec(input logic clr, input logic gate,
                                 input logic ready, input logic expDeq,
                                 input logic expValid,
                                 input logic [WIDTH-1:0] expData,
                                 input logic expSom, input logic expEom,
                                 input logic [31:0] expMsg,
                                 input logic [15:0] expZlm);
    vec_t v;
    v.clr      = clr;
    v.gate     = gate;
    v.ready    = ready;
    v.expDeq   = expDeq;
    v.expValid = expValid;
    v.expData  = expData;
    v.expSom   = expSom;
    v.expEom   = expEom;
    v.expMsg   = expMsg;
    v.expZlm   = expZlm;
    vecs.push_back(v);
  endfunction

  task automatic driveFifo();
    bus.F_EMPTY_N = fifoGate && (fifoQ.size() != 0);
    bus.F_DATA    = (fifoQ.size() != 0) ? fifoQ[0] : '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    CLR          = v.clr;
    bus.M_READY  = v.ready;
    fifoGate     = v.gate;
    driveFifo();
  endtask

  task automatic checkOutput(input string name, input int idx, input vec_t v);
    logic bad;
    bad = (bus.F_DEQ !== v.expDeq) || (bus.M_VALID !== v.expValid) ||
          (bus.M_SOM !== v.expSom) || (bus.M_EOM !== v.expEom) ||
          (msgCount !== v.expMsg) || (zlmCount !== v.expZlm) ||
          (v.expValid && (bus.M_DATA !== v.expData));
    vecCount++;
    if (bad) begin
      missCount++;
      $display("[TB] FAIL %s[%0d]: got deq=%b valid=%b data=%h som=%b eom=%b msg=%0d zlm=%0d, want deq=%b valid=%b data=%h som=%b eom=%b msg=%0d zlm=%0d",
               name, idx, bus.F_DEQ, bus.M_VALID, bus.M_DATA, bus.M_SOM,
               bus.M_EOM, msgCount, zlmCount, v.expDeq, v.expValid,
               v.expData, v.expSom, v.expEom, v.expMsg, v.expZlm);
    end
  endtask

  task automatic checkVal(input string name, input logic [127:0] act,
                          input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs the queued table one cycle per row. Inputs change just after
  // the rising edge, checks happen on the falling edge, and the FIFO
  // model pops after an edge on which F_DEQ was high.
  task automatic runTable(input string name);
    logic deq;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge CLK);
      checkOutput(name, i, vecs[i]);
      deq = bus.F_DEQ;
      @(posedge CLK);
      #1;
      if (deq && fifoQ.size() != 0) void'(fifoQ.pop_front());
    end
    vecs.delete();
  endtask

  // Maximum-length message: every beat must arrive in order, SOM only
  // on the first and EOM only on the last.
  task automatic runLongMessage(input logic [31:0] expMsgAfter);
    int   beats       = 0;
    int   orderErrs   = 0;
    int   framingErrs = 0;
    bit   done        = 0;
    logic deq;
    fifoQ.push_back({112'h0, 16'hFFFF});
    for (int i = 1; i <= 65535; i++) fifoQ.push_back(128'(i));
    for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
      CLR         = 1'b0;
      bus.M_READY = 1'b1;
      fifoGate    = 1'b1;
      driveFifo();
      @(negedge CLK);
      if (bus.M_VALID) begin
        beats++;
        if (bus.M_DATA !== 128'(beats)) orderErrs++;
        if (bus.M_SOM !== (beats == 1)) framingErrs++;
        if (bus.M_EOM !== (beats == 65535)) framingErrs++;
        if (bus.M_EOM) done = 1;
      end
      deq = bus.F_DEQ;
      @(posedge CLK);
      #1;
      if (deq && fifoQ.size() != 0) void'(fifoQ.pop_front());
    end
    checkVal("longBeats", 128'(beats), 128'd65535);
    checkVal("longOrder", 128'(orderErrs), 128'd0);
    checkVal("longFraming", 128'(framingErrs), 128'd0);
    checkVal("longMsgCount", 128'(msgCount), 128'(expMsgAfter));
    checkVal("longBusyAfter", 128'(busy), 128'd0);
  endtask

  initial begin
    vec_t resetVec;
    RST_N         = 1'b0;
    CLR           = 1'b0;
    bus.M_READY   = 1'b1;
    fifoGate      = 1'b1;
    bus.F_EMPTY_N = 1'b0;
    bus.F_DATA    = '0;

`ifdef FIFO_MSG_READER_HDR_PASS_EN
    fifoQ = '{H2, WX, WY, H0};
`else
    fifoQ = '{H3, WA, WB, WC};
`endif
    driveFifo();

    // In reset, with a word waiting, nothing is dequeued and outputs are idle.
    repeat (2) @(negedge CLK);
    resetVec = '{clr: 1'b0, gate: 1'b1, ready: 1'b1, expDeq: 1'b0,
                 expValid: 1'b0, expData: NONE, expSom: 1'b0, expEom: 1'b0,
                 expMsg: 32'd0, expZlm: 16'd0};
    checkOutput("reset", 0, resetVec);
    checkVal("resetBusy", 128'(busy), 128'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

`ifdef FIFO_MSG_READER_HDR_PASS_EN
    // {hdr N=2, X, Y} then {hdr N=0}: header beats carry SOM, an empty
    // message is a single SOM+EOM beat.
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 1, H2,   1, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 1, WX,   0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 1, WY,   0, 1, 32'd1, 16'd0);
    addVec(0, 1, 1, 0, 1, H0,   1, 1, 32'd2, 16'd1);
    addVec(0, 1, 1, 0, 0, NONE, 0, 0, 32'd2, 16'd1);
    runTable("hdrPass");
`else
    // N=3 with a ready consumer: three back-to-back beats.
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 1, WA,   1, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 1, WB,   0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 0, 1, WC,   0, 1, 32'd1, 16'd0);
    addVec(0, 1, 1, 0, 0, NONE, 0, 0, 32'd1, 16'd0);
    runTable("basic");

    // Same message with a 5-cycle stall on the first beat.
    fifoQ = '{H3, WA, WB, WC};
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd1, 16'd0);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd1, 16'd0);
    for (int i = 0; i < 5; i++) addVec(0, 1, 0, 0, 1, WA, 1, 0, 32'd1, 16'd0);
    addVec(0, 1, 1, 1, 1, WA,   1, 0, 32'd1, 16'd0);
    addVec(0, 1, 1, 1, 1, WB,   0, 0, 32'd1, 16'd0);
    addVec(0, 1, 1, 0, 1, WC,   0, 1, 32'd2, 16'd0);
    addVec(0, 1, 1, 0, 0, NONE, 0, 0, 32'd2, 16'd0);
    runTable("stall");

    // Zero-length message followed by a single-word message.
    fifoQ = '{H0, H1, WD};
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd2, 16'd0);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd2, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd2, 16'd1);
    addVec(0, 1, 1, 0, 1, WD,   1, 1, 32'd3, 16'd1);
    addVec(0, 1, 1, 0, 0, NONE, 0, 0, 32'd3, 16'd1);
    runTable("zlm");

    // FIFO availability toggling every cycle during an N=4 payload.
    fifoQ = '{H4, P1, P2, P3, P4};
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd3, 16'd1);
    addVec(0, 0, 1, 0, 0, NONE, 0, 0, 32'd3, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd3, 16'd1);
    addVec(0, 0, 1, 0, 1, P1,   1, 0, 32'd3, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd3, 16'd1);
    addVec(0, 0, 1, 0, 1, P2,   0, 0, 32'd3, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd3, 16'd1);
    addVec(0, 0, 1, 0, 1, P3,   0, 0, 32'd3, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd3, 16'd1);
    addVec(0, 0, 1, 0, 1, P4,   0, 1, 32'd4, 16'd1);
    addVec(0, 1, 1, 0, 0, NONE, 0, 0, 32'd4, 16'd1);
    runTable("toggle");

    // CLR with a beat pending and two words left: the next word is a header.
    fifoQ = '{H4, E1, E2, E3HDR, E4};
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd4, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd4, 16'd1);
    addVec(0, 1, 1, 1, 1, E1,   1, 0, 32'd4, 16'd1);
    addVec(1, 1, 1, 0, 1, E2,   0, 0, 32'd4, 16'd1);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd0, 16'd0);
    addVec(0, 1, 1, 0, 1, E4,   1, 1, 32'd1, 16'd0);
    addVec(0, 1, 1, 0, 0, NONE, 0, 0, 32'd1, 16'd0);
    runTable("clr");

    runLongMessage(32'd2);

    // Asynchronous reset while a first beat is held by the consumer.
    fifoQ = '{H2, Q1, Q2};
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd2, 16'd0);
    addVec(0, 1, 1, 1, 0, NONE, 0, 0, 32'd2, 16'd0);
    addVec(0, 1, 0, 0, 1, Q1,   1, 0, 32'd2, 16'd0);
    runTable("preReset");
    #2;
    RST_N = 1'b0;
    #1;
    checkVal("asyncValid", 128'(bus.M_VALID), 128'd0);
    checkVal("asyncSom", 128'(bus.M_SOM), 128'd0);
    checkVal("asyncData", bus.M_DATA, 128'd0);
    checkVal("asyncDeq", 128'(bus.F_DEQ), 128'd0);
    checkVal("asyncMsg", 128'(msgCount), 128'd0);
    checkVal("asyncBusy", 128'(busy), 128'd0);
    fifoQ.delete();
    driveFifo();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fifo_msg_reader.md
# fifo_msg_reader

Read-side framer for the SRL FIFO family: drains a FIFO through its ENQ/DEQ-style dequeue port (FULL_N/EMPTY_N protocol, data valid whenever EMPTY_N is high) and turns the word stream into length-delimited messages on a ready/valid output. Each message in the FIFO is one header word carrying the payload word count, followed by that many payload words. The block sits between a staging FIFO and a downstream consumer such as a DMA or worker port. It supplies the SOM/EOM framing and message accounting that the FIFO itself does not provide.

## Interface
- width, 128, data word width (FIFO and output)
- lenw, 16, header length field width; length = F_DATA[lenw-1:0], lenw ≤ width
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- CLR  in  1  synchronous clear, same effect as reset
- F_EMPTY_N  in  1  FIFO has a word; F_DATA valid
- F_DATA  in  width  FIFO head word
- F_DEQ  out  1  dequeue strobe to FIFO (combinational)
- M_VALID  out  1  output beat valid (registered)
- M_READY  in  1  consumer accepts beat
- M_DATA  out  width  output beat data (registered)
- M_SOM  out  1  first beat of message (registered)
- M_EOM  out  1  last beat of message (registered)
- MSG_COUNT  out  32  completed messages, wraps modulo 2^32
- ZLM_COUNT  out  16  zero-length messages consumed, saturates at 16'hFFFF
- BUSY  out  1  state ≠ IDLE or M_VALID

## Operation
- Reset/CLR: state=IDLE, remaining=0, M_VALID=0, M_SOM=0, M_EOM=0, M_DATA=0, counters=0. F_DEQ=0 while RST_N low or CLR high. CLR drops an undelivered beat.
- Output register is 1 deep. Define slot_free = !M_VALID || M_READY.
- IDLE: F_DEQ = F_EMPTY_N (header mode). On dequeue, N = F_DATA[lenw-1:0].
  - N=0: stay in IDLE, ZLM_COUNT+1 (saturating), MSG_COUNT unchanged.
  - N>0: remaining ← N, first ← 1, go to DATA.
- DATA: F_DEQ = F_EMPTY_N && slot_free. On dequeue:
  - M_DATA ← F_DATA, M_VALID ← 1.
  - M_SOM ← first, then first ← 0.
  - M_EOM ← (remaining==1).
  - remaining ← remaining−1.
  - If remaining==1: go to IDLE, MSG_COUNT+1.
- Accepted beat (M_VALID && M_READY) with no new load: M_VALID ← 0, M_SOM and M_EOM ← 0.
- Held beat (M_VALID && !M_READY): M_DATA, M_SOM and M_EOM stay stable. F_DEQ=0 in DATA.
- F_DEQ is never high while F_EMPTY_N is low (underflow protection).
- remaining is lenw bits wide. N = 2^lenw−1 is legal and must complete without wrap.

## Timing
- Header dequeued at edge t. The first payload dequeue is at the earliest at t+1, and M_VALID is high after that edge.
- Sustained throughput is 1 payload word per cycle with M_READY and F_EMPTY_N held high. There are no bubbles within a message.
- Without HDR pass, every message costs 1 header cycle. Back-to-back messages therefore show a 1-cycle M_VALID gap when M_READY is high.
- IDLE header consumption does not depend on M_READY. The pending last beat of the previous message may still be waiting in the register.
- MSG_COUNT increments on the edge that loads the EOM beat, not on its acceptance.
- Asynchronous reset mid-message: all outputs go to reset values immediately. FIFO contents are the FIFO's concern.

## Configuration
- FIFO_MSG_READER_HDR_PASS_EN defined:
  - In IDLE the header is also loaded into the output register, so F_DEQ = F_EMPTY_N && slot_free.
  - The header beat carries M_SOM=1, with M_EOM=1 when N=0.
  - For N>0 the first payload beat has M_SOM=0.
  - For N=0, both MSG_COUNT and ZLM_COUNT increment.
- Not defined: headers are consumed silently as described above, and a zero-length message produces no output beat.

## Test plan
- Reset, then FIFO holds {hdr N=3, A, B, C} with M_READY=1: beats A(SOM),B,C(EOM) on 3 consecutive cycles; MSG_COUNT=1; F_DEQ high for 4 consecutive cycles.
- Same message with M_READY low for 5 cycles after the first beat: A stays stable with SOM=1, F_DEQ=0 during the stall, no word lost or duplicated; then B and C follow.
- FIFO holds {hdr N=0, hdr N=1, D}: ZLM_COUNT=1, single beat D with SOM=EOM=1, MSG_COUNT=1.
- F_EMPTY_N toggles every cycle during an N=4 payload: F_DEQ only when F_EMPTY_N=1, exactly 4 beats, EOM only on the 4th.
- CLR pulsed while M_VALID=1 mid-message (remaining=2): next cycle M_VALID=0, state IDLE, counters 0. The next FIFO word is treated as a header.
- With FIFO_MSG_READER_HDR_PASS_EN, {hdr N=2, X, Y}: beats hdr(SOM), X, Y(EOM); then {hdr N=0} gives one beat with SOM=EOM=1, MSG_COUNT=2, ZLM_COUNT=1.
